// File: rtl/lba_pkg.sv
// Shared types and constants for the line/burst adaptor.
// Optional performance counters are enabled with LINE_BURST_ADAPTOR_PERF_EN.
package lba_pkg;

  localparam int LINE_BITS     = 256;
  localparam int BEAT_BITS     = 64;
  localparam int BEATS         = 4;
  localparam int OFFSET_BITS   = 5;
  localparam int BEAT_IDX_BITS = 2;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    READ_BURST  = 2'd1,
    WRITE_BURST = 2'd2,
    DONE        = 2'd3
  } lba_state_t;

  typedef logic [LINE_BITS-1:0]     line_t;
  typedef logic [BEAT_BITS-1:0]     beat_t;
  typedef logic [BEAT_IDX_BITS-1:0] beat_idx_t;

  function automatic logic is_last_beat(input beat_idx_t idx);
    return idx == BEAT_IDX_BITS'(BEATS - 1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/lba_line_buffer.sv
// One cache line of storage: full-line load, per-beat write and per-beat read mux.
// Holds the write line while it is split and the read line while it is assembled.
module lba_line_buffer #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int IDX_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [LINE_WIDTH-1:0] load_data,
  input  logic                  beat_we,
  input  logic [IDX_BITS-1:0]   beat_widx,
  input  logic [BEAT_WIDTH-1:0] beat_wdata,
  input  logic [IDX_BITS-1:0]   beat_ridx,
  output logic [BEAT_WIDTH-1:0] beat_rdata,
  output logic [LINE_WIDTH-1:0] line
);

  logic [LINE_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end else if (beat_we) begin
      data_q[beat_widx*BEAT_WIDTH +: BEAT_WIDTH] <= beat_wdata;
    end
  end

  assign beat_rdata = data_q[beat_ridx*BEAT_WIDTH +: BEAT_WIDTH];
  assign line       = data_q;

endmodule

// File: rtl/line_burst_adaptor.sv
// Serves cache line read/write requests as 4-beat bursts on the memory port.
// Define LINE_BURST_ADAPTOR_PERF_EN to add saturating read/write/abandon counters.
module line_burst_adaptor
  import lba_pkg::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [ADDR_WIDTH-1:0] line_addr,
  input  logic [LINE_WIDTH-1:0] line_wdata,
  output logic [LINE_WIDTH-1:0] line_rdata,
  output logic                  line_resp,
  output logic [ADDR_WIDTH-1:0] burst_addr,
  output logic                  burst_read,
  output logic                  burst_write,
  output logic [BEAT_WIDTH-1:0] burst_wdata,
  input  logic [BEAT_WIDTH-1:0] burst_rdata,
  input  logic                  burst_resp,
`ifdef LINE_BURST_ADAPTOR_PERF_EN
  output logic [31:0]           perf_reads,
  output logic [31:0]           perf_writes,
  output logic [31:0]           perf_abandoned,
`endif
  output logic [1:0]            state
);

  // Handshake: line_read/line_write are held by the requester until the cycle
  // line_resp is high; a memory beat transfers on every edge with burst_resp=1
  // while burst_read or burst_write is high, and is never aborted once started.

  lba_state_t              state_q, state_d;
  beat_idx_t               beat_cnt;
  logic                    op_write;
  logic [ADDR_WIDTH-1:0]   req_line_addr;
  logic                    req_match;
  logic                    last_beat;
  logic                    buf_load, buf_we;
  logic [BEAT_WIDTH-1:0]   buf_beat;

  assign req_line_addr = {line_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign last_beat     = is_last_beat(beat_cnt);

  // A read request only matches while no write is asserted, since write would win.
  assign req_match = (req_line_addr == burst_addr) &&
                     (op_write ? line_write : (line_read && !line_write));

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (line_write)     state_d = WRITE_BURST;
        else if (line_read) state_d = READ_BURST;
      end
      READ_BURST, WRITE_BURST: begin
        if (burst_resp && last_beat) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    line_resp   = 1'b0;
    burst_wdata = '0;
    buf_load    = 1'b0;
    buf_we      = 1'b0;
    case (state_q)
      IDLE:        buf_load    = line_write;
      READ_BURST:  buf_we      = burst_resp;
      WRITE_BURST: burst_wdata = buf_beat;
      DONE:        line_resp   = req_match;
      default: ;
    endcase
  end

  // Burst requests are registered from the next state so they cover exactly the burst states.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt    <= '0;
      op_write    <= 1'b0;
      burst_addr  <= '0;
      burst_read  <= 1'b0;
      burst_write <= 1'b0;
    end else begin
      burst_read  <= (state_d == READ_BURST);
      burst_write <= (state_d == WRITE_BURST);
      if (state_q == IDLE) begin
        beat_cnt <= '0;
        if (line_write || line_read) begin
          op_write   <= line_write;
          burst_addr <= req_line_addr;
        end
      end else if ((state_q == READ_BURST || state_q == WRITE_BURST) && burst_resp) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
    end
  end

  lba_line_buffer #(
    .LINE_WIDTH (LINE_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH),
    .IDX_BITS   (BEAT_IDX_BITS)
  ) u_line_buffer (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .load_data  (line_wdata),
    .beat_we    (buf_we),
    .beat_widx  (beat_cnt),
    .beat_wdata (burst_rdata),
    .beat_ridx  (beat_cnt),
    .beat_rdata (buf_beat),
    .line       (line_rdata)
  );

`ifdef LINE_BURST_ADAPTOR_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_reads     <= '0;
      perf_writes    <= '0;
      perf_abandoned <= '0;
    end else if (state_q == DONE) begin
      if (!line_resp)    perf_abandoned <= sat_inc(perf_abandoned);
      else if (op_write) perf_writes    <= sat_inc(perf_writes);
      else               perf_reads     <= sat_inc(perf_reads);
    end
  end
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed and random checks of line_burst_adaptor against a line-level reference model.
// Also checks the counters when built with LINE_BURST_ADAPTOR_PERF_EN.
module tb_line_burst_adaptor;
  import lba_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         line_read = 1'b0, line_write = 1'b0;
  logic [31:0]  line_addr = '0;
  logic [255:0] line_wdata = '0;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  burst_addr;
  logic         burst_read, burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;
  logic [1:0]   dut_state;
`ifdef LINE_BURST_ADAPTOR_PERF_EN
  logic [31:0]  perf_reads, perf_writes, perf_abandoned;
`endif

  line_burst_adaptor dut (
    .clk(clk), .rst(rst),
    .line_read(line_read), .line_write(line_write),
    .line_addr(line_addr), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .burst_addr(burst_addr), .burst_read(burst_read), .burst_write(burst_write),
    .burst_wdata(burst_wdata), .burst_rdata(burst_rdata), .burst_resp(burst_resp),
`ifdef LINE_BURST_ADAPTOR_PERF_EN
    .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_abandoned(perf_abandoned),
`endif
    .state(dut_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int exp_reads = 0, exp_writes = 0, exp_aband = 0;
  int beats_seen = 0, resp_count = 0;
  logic [63:0] exp_q[$];
  logic [63:0] wq[$];

  // memory model: stall_cfg[k] idle cycles before beat k, beats driven on the falling edge
  logic [63:0] mem_beats [4];
  int          stall_cfg [4];
  int          mb = 0, stall_left = 0;

  always @(negedge clk) begin
    if (rst || !(burst_read || burst_write)) begin
      burst_resp = 1'b0;
      mb = 0;
      stall_left = stall_cfg[0];
    end else if (mb > 3) begin
      burst_resp = 1'b0;
    end else if (stall_left > 0) begin
      burst_resp = 1'b0;
      stall_left--;
    end else begin
      burst_resp  = 1'b1;
      burst_rdata = mem_beats[mb];
      if (burst_write) wq.push_back(burst_wdata);
      beats_seen++;
      mb++;
      stall_left = (mb < 4) ? stall_cfg[mb] : 0;
    end
  end

  always @(negedge clk) if (line_resp) resp_count++;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: present one request, follow it to line_resp or to abandonment
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wdata, input int drop_after, input bit chained,
                         output bit got_resp, output int lat, output logic [255:0] rdata,
                         output logic [31:0] baddr, output logic saw_br, output logic saw_bw,
                         output int nbeats);
    int b0;
    bit fin;
    if (!chained) @(negedge clk);
    line_read = rd; line_write = wr; line_addr = addr; line_wdata = wdata;
    b0 = beats_seen;
    @(posedge clk);
    got_resp = 0; lat = 0; fin = 0; rdata = '0; baddr = '0; saw_br = 0; saw_bw = 0;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      lat++;
      if (c == 0) begin saw_br = burst_read; saw_bw = burst_write; baddr = burst_addr; end
      if (line_resp) begin got_resp = 1; rdata = line_rdata; fin = 1; end
      else if (c > 0 && dut_state == 2'(IDLE)) fin = 1;
      if (drop_after >= 0 && beats_seen - b0 >= drop_after) begin line_read = 0; line_write = 0; end
    end
    nbeats = beats_seen - b0;
    check("txn_finished", 256'(fin), 256'(1'b1));
    @(posedge clk);
    #1;
    line_read = 0; line_write = 0;
  endtask

  function automatic logic [255:0] beats_to_line();
    logic [255:0] l;
    for (int i = 0; i < 4; i++) l[64*i +: 64] = mem_beats[i];
    return l;
  endfunction

  task automatic check_writes(input string tag, input logic [255:0] wdata);
    for (int i = 0; i < 4; i++) exp_q.push_back(wdata[64*i +: 64]);
    check({tag, "_nbeats"}, 256'(wq.size()), 256'(exp_q.size()));
    while (exp_q.size() > 0 && wq.size() > 0) check({tag, "_wbeat"}, 256'(wq.pop_front()), 256'(exp_q.pop_front()));
    exp_q.delete();
    wq.delete();
  endtask

  bit           got;
  int           lat, nb, b0, exp_lat;
  logic [255:0] rd_line, wline;
  logic [31:0]  baddr, raddr;
  logic         sbr, sbw;
  int           r0;

  initial begin
    stall_cfg = '{0, 0, 0, 0};
    mem_beats = '{64'h0, 64'h0, 64'h0, 64'h0};
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_state", 256'(dut_state), 256'(2'(IDLE)));
    check("rst_line_resp", 256'(line_resp), 256'(1'b0));
    check("rst_burst_read", 256'(burst_read), 256'(1'b0));
    check("rst_burst_write", 256'(burst_write), 256'(1'b0));
    check("rst_burst_addr", 256'(burst_addr), 256'(32'h0));
    check("rst_burst_wdata", 256'(burst_wdata), 256'(64'h0));
    check("rst_line_rdata", line_rdata, 256'h0);

    // read at 0x1024, no stalls
    mem_beats = '{{16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}};
    run_txn(1, 0, 32'h0000_1024, '0, -1, 0, got, lat, rd_line, baddr, sbr, sbw, nb);
    check("rd_resp", 256'(got), 256'(1'b1));
    check("rd_addr", 256'(baddr), 256'(32'h0000_1020));
    check("rd_req", 256'({sbr, sbw}), 256'(2'b10));
    check("rd_latency", 256'(lat), 256'(5));
    check("rd_data", rd_line, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
    exp_reads++;

    // write at 0x40 with 2 stall cycles before beat 2
    stall_cfg = '{0, 0, 2, 0};
    wline = {{16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}}};
    run_txn(0, 1, 32'h0000_0040, wline, -1, 0, got, lat, rd_line, baddr, sbr, sbw, nb);
    check("wr_resp", 256'(got), 256'(1'b1));
    check("wr_addr", 256'(baddr), 256'(32'h40));
    check("wr_latency", 256'(lat), 256'(7));
    check("wr_write_low_after", 256'(burst_write), 256'(1'b0));
    check_writes("wr", wline);
    exp_writes++;

    // simultaneous read and write: write wins
    stall_cfg = '{0, 0, 0, 0};
    wline = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_txn(1, 1, 32'h0000_0080, wline, -1, 0, got, lat, rd_line, baddr, sbr, sbw, nb);
    check("both_req", 256'({sbr, sbw}), 256'(2'b01));
    check("both_resp", 256'(got), 256'(1'b1));
    check_writes("both", wline);
    exp_writes++;

    // read abandoned after beat 1: burst still completes, no response
    run_txn(1, 0, 32'h0000_0100, '0, 2, 0, got, lat, rd_line, baddr, sbr, sbw, nb);
    check("aband_resp", 256'(got), 256'(1'b0));
    check("aband_beats", 256'(nb), 256'(4));
    exp_aband++;
`ifdef LINE_BURST_ADAPTOR_PERF_EN
    check("perf_reads_a", 256'(perf_reads), 256'(exp_reads));
    check("perf_writes_a", 256'(perf_writes), 256'(exp_writes));
    check("perf_aband_a", 256'(perf_abandoned), 256'(exp_aband));
`endif

    // reset during beat 2 of a read
    @(negedge clk);
    line_read = 1; line_addr = 32'h0000_0180;
    b0 = beats_seen;
    for (int c = 0; c < 50 && beats_seen - b0 < 2; c++) @(negedge clk);
    check("rst_mid_reached", 256'(beats_seen - b0 >= 2), 256'(1'b1));
    rst = 1'b1; line_read = 0;
    @(negedge clk);
    check("rst_mid_state", 256'(dut_state), 256'(2'(IDLE)));
    check("rst_mid_burst_read", 256'(burst_read), 256'(1'b0));
    check("rst_mid_line_resp", 256'(line_resp), 256'(1'b0));
    rst = 1'b0;
    exp_reads = 0; exp_writes = 0; exp_aband = 0;
    for (int i = 0; i < 4; i++) mem_beats[i] = {$urandom, $urandom};
    run_txn(1, 0, 32'h0000_0200, '0, -1, 0, got, lat, rd_line, baddr, sbr, sbw, nb);
    check("post_rst_resp", 256'(got), 256'(1'b1));
    check("post_rst_data", rd_line, beats_to_line());
    exp_reads++;

    // back-to-back read then write
    r0 = resp_count;
    run_txn(1, 0, 32'h0000_0300, '0, -1, 0, got, lat, rd_line, baddr, sbr, sbw, nb);
    check("b2b_rd_data", rd_line, beats_to_line());
    wline = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_txn(0, 1, 32'h0000_0340, wline, -1, 1, got, lat, rd_line, baddr, sbr, sbw, nb);
    check("b2b_wr_immediate", 256'(sbw), 256'(1'b1));
    check("b2b_wr_latency", 256'(lat), 256'(5));
    check_writes("b2b", wline);
    @(negedge clk);
    check("b2b_resp_pulses", 256'(resp_count - r0), 256'(2));
    exp_reads++; exp_writes++;

    // random traffic
    for (int t = 0; t < 16; t++) begin
      int kind;
      kind = $urandom_range(0, 2);
      raddr = $urandom;
      wline = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      exp_lat = 5;
      for (int i = 0; i < 4; i++) begin
        stall_cfg[i] = $urandom_range(0, 3);
        exp_lat += stall_cfg[i];
        mem_beats[i] = {$urandom, $urandom};
      end
      run_txn(kind != 1, kind != 0, raddr, wline, -1, 0, got, lat, rd_line, baddr, sbr, sbw, nb);
      check("rnd_resp", 256'(got), 256'(1'b1));
      check("rnd_addr", 256'(baddr), 256'({raddr[31:5], 5'b0}));
      check("rnd_latency", 256'(lat), 256'(exp_lat));
      if (kind == 0) begin
        check("rnd_rd_data", rd_line, beats_to_line());
        exp_reads++;
      end else begin
        check_writes("rnd", wline);
        exp_writes++;
      end
    end

`ifdef LINE_BURST_ADAPTOR_PERF_EN
    check("perf_reads", 256'(perf_reads), 256'(exp_reads));
    check("perf_writes", 256'(perf_writes), 256'(exp_writes));
    check("perf_aband", 256'(perf_abandoned), 256'(exp_aband));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
